// File: rtl/vga_pkg.sv
// Shared constants, types and the per-axis bounce step for the VGA bounce generator.
package vga_pkg;

    localparam int unsigned XD    = 640;
    localparam int unsigned YD    = 480;
    localparam int unsigned RGB_W = 12;
    localparam int unsigned CNT_W = 10;
    localparam int unsigned POS_W = 11;

    typedef logic [RGB_W-1:0] rgb_t;

    typedef enum logic [1:0] {
        PAUSE = 2'd0,
        RUN   = 2'd1,
        ARMED = 2'd2
    } bounce_state_t;

    typedef struct packed {
        logic             neg;
        logic [CNT_W-1:0] pos;
    } axis_t;

    // One frame of motion on one axis; hi is the far wall, lo the near wall.
    function automatic axis_t axis_move(
        input axis_t            cur,
        input logic [POS_W-1:0] lo,
        input logic [POS_W-1:0] hi,
        input logic [POS_W-1:0] size,
        input logic [POS_W-1:0] step
    );
        axis_t            nxt;
        logic [POS_W-1:0] p;
        nxt = cur;
        p   = {1'b0, cur.pos};
        if (!cur.neg) begin
            if (p + size + step > hi) begin
                nxt.pos = CNT_W'(hi - size);
                nxt.neg = 1'b1;
            end else begin
                nxt.pos = CNT_W'(p + step);
            end
        end else begin
            if (p < lo + step) begin
                nxt.pos = CNT_W'(lo);
                nxt.neg = 1'b0;
            end else begin
                nxt.pos = CNT_W'(p - step);
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/vga_frame_tick.sv
// One-clock pulse on entry to row 480 / column 0, robust to counters held for several clocks.
module vga_frame_tick
    import vga_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] x_count_i,
    input  logic [CNT_W-1:0] y_count_i,
    output logic             frame_tick_c_o
);

    logic cond_c;
    logic cond_q;

    assign cond_c = (y_count_i == CNT_W'(YD)) && (x_count_i == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cond_q <= 1'b0;
        end else begin
            cond_q <= cond_c;
        end
    end

    assign frame_tick_c_o = cond_c && !cond_q;

endmodule

// File: rtl/vga_bounce_gen.sv
// Bouncing-square pixel stage with run/pause/single-step motion control.
// Define VGA_BORDER_EN to draw a 4-pixel white frame and bounce inside it.
module vga_bounce_gen
    import vga_pkg::*;
#(
    parameter int unsigned SIZE     = 16,
    parameter int unsigned STEP     = 2,
    parameter int unsigned INIT_X   = 100,
    parameter int unsigned INIT_Y   = 100,
    parameter rgb_t        BALL_RGB = 12'hF00
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] x_count,
    input  logic [CNT_W-1:0] y_count,
    input  logic             vid_on,
    input  logic             h_sync_in,
    input  logic             v_sync_in,
    input  rgb_t             bg_rgb,
    input  logic             run,
    input  logic             step,
    output rgb_t             rgb,
    output logic             h_sync,
    output logic             v_sync,
    output logic [CNT_W-1:0] ball_x,
    output logic [CNT_W-1:0] ball_y
);

`ifdef VGA_BORDER_EN
    localparam int unsigned BORDER = 4;
`else
    localparam int unsigned BORDER = 0;
`endif

    localparam logic [POS_W-1:0] LO_P   = POS_W'(BORDER);
    localparam logic [POS_W-1:0] X_HI   = POS_W'(XD - BORDER);
    localparam logic [POS_W-1:0] Y_HI   = POS_W'(YD - BORDER);
    localparam logic [POS_W-1:0] SIZE_P = POS_W'(SIZE);
    localparam logic [POS_W-1:0] STEP_P = POS_W'(STEP);

    localparam logic [1:0] S_PAUSE = 2'(PAUSE);
    localparam logic [1:0] S_RUN   = 2'(RUN);
    localparam logic [1:0] S_ARMED = 2'(ARMED);

    logic       frame_tick_c;
    logic [1:0] state_q, state_d;
    axis_t      bx_q, bx_d;
    axis_t      by_q, by_d;
    logic       move_en_c;

    vga_frame_tick u_frame_tick (
        .clk            (clk),
        .reset          (reset),
        .x_count_i      (x_count),
        .y_count_i      (y_count),
        .frame_tick_c_o (frame_tick_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_PAUSE;
            bx_q.neg   <= 1'b0;
            bx_q.pos   <= CNT_W'(INIT_X);
            by_q.neg   <= 1'b0;
            by_q.pos   <= CNT_W'(INIT_Y);
        end else begin
            state_q <= state_d;
            bx_q    <= bx_d;
            by_q    <= by_d;
        end
    end

    // Motion control; position only changes on the frame tick inside vertical blanking.
    always_comb begin
        state_d   = state_q;
        bx_d      = bx_q;
        by_d      = by_q;
        move_en_c = 1'b0;
        case (state_q)
            S_PAUSE: begin
                if (run) begin
                    state_d = S_RUN;
                end else if (step) begin
                    state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                move_en_c = frame_tick_c;
                if (run) begin
                    state_d = S_RUN;
                end else if (frame_tick_c) begin
                    state_d = S_PAUSE;
                end
            end
            S_RUN: begin
                move_en_c = frame_tick_c;
                if (!run) begin
                    state_d = S_PAUSE;
                end
            end
            default: state_d = S_PAUSE;
        endcase
        if (move_en_c) begin
            bx_d = axis_move(bx_q, LO_P, X_HI, SIZE_P, STEP_P);
            by_d = axis_move(by_q, LO_P, Y_HI, SIZE_P, STEP_P);
        end
    end

    logic [POS_W-1:0] xc, yc, bxw, byw;
    logic             inside_c;
    logic             border_c;
    rgb_t             rgb_d, rgb_q;
    logic             hs_q, vs_q;

    always_comb begin
        xc       = {1'b0, x_count};
        yc       = {1'b0, y_count};
        bxw      = {1'b0, bx_q.pos};
        byw      = {1'b0, by_q.pos};
        inside_c = (xc >= bxw) && (xc < bxw + SIZE_P) &&
                   (yc >= byw) && (yc < byw + SIZE_P);
`ifdef VGA_BORDER_EN
        border_c = (x_count < CNT_W'(BORDER)) || (x_count > CNT_W'(XD - BORDER - 1)) ||
                   (y_count < CNT_W'(BORDER)) || (y_count > CNT_W'(YD - BORDER - 1));
`else
        border_c = 1'b0;
`endif
        rgb_d = '0;
        if (vid_on) begin
            if (border_c) begin
                rgb_d = 12'hFFF;
            end else if (inside_c) begin
                rgb_d = BALL_RGB;
            end else begin
                rgb_d = bg_rgb;
            end
        end
    end

    // Colour and syncs share one register stage so they stay aligned.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rgb_q <= '0;
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
        end else begin
            rgb_q <= rgb_d;
            hs_q  <= h_sync_in;
            vs_q  <= v_sync_in;
        end
    end

    assign rgb    = rgb_q;
    assign h_sync = hs_q;
    assign v_sync = vs_q;
    assign ball_x = bx_q.pos;
    assign ball_y = by_q.pos;

endmodule
